// File: rtl/sigpulse_train_if.sv
// Bundle of per-channel control, configuration and status lines for sigpulse_train.
// Handshake: io_en is a one-cycle start strobe taken only by an IDLE, non-aborted channel;
// busy marks a running train; pulse_valid is a one-cycle completion strobe with no backpressure.
interface sigpulse_train_if #(
  parameter int N_CH       = 4,
  parameter int _RAM_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [N_CH-1:0]            io_en;
  logic [N_CH-1:0]            pwm_dis;
  logic [N_CH*_RAM_WIDTH-1:0] io_delay;
  logic [N_CH*_RAM_WIDTH-1:0] io_pulseWidth;
  logic [N_CH*_RAM_WIDTH-1:0] io_period;
  logic [N_CH*CNT_WIDTH-1:0]  io_pulseCnt;
  logic [N_CH-1:0]            io_defaultLevel;
  logic [N_CH-1:0]            io_pulseOut;
  logic [N_CH-1:0]            busy;
  logic [N_CH-1:0]            pulse_valid;
  logic [N_CH*3-1:0]          dbg_state;

  modport master (
    output io_en, pwm_dis, io_delay, io_pulseWidth, io_period, io_pulseCnt, io_defaultLevel,
    input  io_pulseOut, busy, pulse_valid, dbg_state
  );

  modport slave (
    input  io_en, pwm_dis, io_delay, io_pulseWidth, io_period, io_pulseCnt, io_defaultLevel,
    output io_pulseOut, busy, pulse_valid, dbg_state
  );
endinterface

// File: rtl/sigpulse_train.sv
// Multi-channel pulse-train generator: per-channel delay, high width, period and pulse count,
// with level-sensitive abort and a one-cycle completion strobe.
module sigpulse_train #(
  parameter int N_CH       = 4,
  parameter int _RAM_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic             io_clk,
  input logic             io_rst_n,
  sigpulse_train_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_NULL  = 3'd4
  } state_t;

  localparam logic [_RAM_WIDTH-1:0] ONE_W = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  ONE_C = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t                st_q, st_d;
    logic [_RAM_WIDTH-1:0] dly_q, wid_q, low_q;
    logic [_RAM_WIDTH-1:0] cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, pcnt_q, pcnt_d;
    logic                  def_q, out_q, out_d, pv_q, pv_d, load;
    logic [_RAM_WIDTH-1:0] d_in, w_in, p_in;
    logic [CNT_WIDTH-1:0]  c_in;

    assign d_in = bus.io_delay[i*_RAM_WIDTH +: _RAM_WIDTH];
    assign w_in = bus.io_pulseWidth[i*_RAM_WIDTH +: _RAM_WIDTH];
    assign p_in = bus.io_period[i*_RAM_WIDTH +: _RAM_WIDTH];
    assign c_in = bus.io_pulseCnt[i*CNT_WIDTH +: CNT_WIDTH];

    // Phase counters compare against field-1, so they never exceed the field and cannot overflow.
    always_comb begin
      st_d   = st_q;
      cyc_d  = cyc_q;
      pcnt_d = pcnt_q;
      out_d  = out_q;
      pv_d   = 1'b0;
      load   = 1'b0;
      if (st_q != S_IDLE && bus.pwm_dis[i]) begin
        st_d   = S_IDLE;
        cyc_d  = '0;
        pcnt_d = '0;
        out_d  = def_q;
      end else begin
        case (st_q)
          S_IDLE: begin
            out_d = bus.io_defaultLevel[i];
            if (bus.io_en[i] && !bus.pwm_dis[i]) begin
              load   = 1'b1;
              cyc_d  = '0;
              pcnt_d = '0;
              if (w_in == '0) begin
                st_d = S_NULL;
              end else if (d_in == '0) begin
                st_d  = S_HIGH;
                out_d = ~bus.io_defaultLevel[i];
              end else begin
                st_d = S_DELAY;
              end
            end
          end
          S_DELAY: begin
            if (cyc_q == dly_q - ONE_W) begin
              st_d  = S_HIGH;
              cyc_d = '0;
              out_d = ~def_q;
            end else begin
              cyc_d = cyc_q + ONE_W;
            end
          end
          S_HIGH: begin
            if (cyc_q == wid_q - ONE_W) begin
              cyc_d  = '0;
              pcnt_d = pcnt_q + ONE_C;
              out_d  = def_q;
              // The final pulse ends the train directly; there is no trailing low phase.
              if (cnt_q != '0 && pcnt_q == cnt_q - ONE_C) begin
                st_d   = S_IDLE;
                pcnt_d = '0;
                pv_d   = 1'b1;
              end else begin
                st_d = S_LOW;
              end
            end else begin
              cyc_d = cyc_q + ONE_W;
            end
          end
          S_LOW: begin
            if (cyc_q == low_q - ONE_W) begin
              st_d  = S_HIGH;
              cyc_d = '0;
              out_d = ~def_q;
            end else begin
              cyc_d = cyc_q + ONE_W;
            end
          end
          S_NULL: begin
            st_d = S_IDLE;
            pv_d = 1'b1;
          end
          default: begin
            st_d  = S_IDLE;
            cyc_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
        st_q   <= S_IDLE;
        cyc_q  <= '0;
        pcnt_q <= '0;
        out_q  <= 1'b0;
        pv_q   <= 1'b0;
        def_q  <= 1'b0;
        dly_q  <= '0;
        wid_q  <= '0;
        low_q  <= '0;
        cnt_q  <= '0;
      end else begin
        st_q   <= st_d;
        cyc_q  <= cyc_d;
        pcnt_q <= pcnt_d;
        out_q  <= out_d;
        pv_q   <= pv_d;
        if (load) begin
          def_q <= bus.io_defaultLevel[i];
          dly_q <= d_in;
          wid_q <= w_in;
          // A low phase of at least one cycle always separates pulses.
          low_q <= (p_in > w_in) ? (p_in - w_in) : ONE_W;
          cnt_q <= c_in;
        end
      end
    end

    assign bus.io_pulseOut[i]       = out_q;
    assign bus.busy[i]              = (st_q != S_IDLE);
    assign bus.pulse_valid[i]       = pv_q;
    assign bus.dbg_state[i*3 +: 3]  = st_q;
  end

endmodule

// File: tb/tb_sigpulse_train.sv
// Self-checking bench for sigpulse_train: per-channel expected waveforms are queued at start
// time and compared cycle by cycle against {io_pulseOut, busy, pulse_valid}.
module tb_sigpulse_train;
  localparam int N_CH = 4;
  localparam int W    = 32;
  localparam int CW   = 16;

  logic io_clk = 1'b0;
  logic io_rst_n;
  int   tests_run = 0;
  int   failed    = 0;

  // Per-channel scoreboard; entry = {pulseOut, busy, pulse_valid}, one per cycle after the start edge.
  logic [2:0] exp_q[N_CH][$];

  sigpulse_train_if #(.N_CH(N_CH), ._RAM_WIDTH(W), .CNT_WIDTH(CW)) bus ();

  sigpulse_train #(.N_CH(N_CH), ._RAM_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .io_clk   (io_clk),
    .io_rst_n (io_rst_n),
    .bus      (bus)
  );

  always #5 io_clk = ~io_clk;

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int d, input int w, input int p, input int c);
    bus.io_delay[ch*W +: W]      = W'(d);
    bus.io_pulseWidth[ch*W +: W] = W'(w);
    bus.io_period[ch*W +: W]     = W'(p);
    bus.io_pulseCnt[ch*CW +: CW] = CW'(c);
  endtask

  task automatic set_defaults(input logic [N_CH-1:0] v);
    bus.io_defaultLevel = v;
    tick();
    tick();
  endtask

  // Reference waveform built phase by phase; stop_after > 0 models an abort after that many full pulses.
  task automatic push_train(input int ch, input int d, input int w, input int p, input int c,
                            input logic def, input int stop_after);
    int l;
    int n;
    l = (p > w) ? p - w : 1;
    if (w == 0) begin
      exp_q[ch].push_back({def, 2'b10});
      exp_q[ch].push_back({def, 2'b01});
      return;
    end
    for (int i = 0; i < d; i++) exp_q[ch].push_back({def, 2'b10});
    n = (stop_after > 0) ? stop_after : c;
    for (int pl = 1; pl <= n; pl++) begin
      for (int i = 0; i < w; i++) exp_q[ch].push_back({~def, 2'b10});
      if (pl < n || stop_after > 0)
        for (int i = 0; i < l; i++) exp_q[ch].push_back({def, 2'b10});
    end
    if (stop_after > 0) exp_q[ch].push_back({def, 2'b00});
    else                exp_q[ch].push_back({def, 2'b01});
  endtask

  task automatic test_reset();
    io_rst_n            = 1'b0;
    bus.io_en           = '0;
    bus.pwm_dis         = '0;
    bus.io_delay        = '0;
    bus.io_pulseWidth   = '0;
    bus.io_period       = '0;
    bus.io_pulseCnt     = '0;
    bus.io_defaultLevel = 4'b0110;
    #3;
    tests_run++;
    if (bus.io_pulseOut !== 4'b0000) begin
      failed++; $display("FAIL reset_out got=%b exp=%b", bus.io_pulseOut, 4'b0000);
    end
    tests_run++;
    if (bus.busy !== 4'b0000) begin
      failed++; $display("FAIL reset_busy got=%b exp=%b", bus.busy, 4'b0000);
    end
    tests_run++;
    if (bus.pulse_valid !== 4'b0000) begin
      failed++; $display("FAIL reset_pv got=%b exp=%b", bus.pulse_valid, 4'b0000);
    end
    tests_run++;
    if (bus.dbg_state !== 12'h000) begin
      failed++; $display("FAIL reset_state got=%h exp=%h", bus.dbg_state, 12'h000);
    end
    tick();
    tests_run++;
    if (bus.io_pulseOut !== 4'b0000) begin
      failed++; $display("FAIL reset_hold_out got=%b exp=%b", bus.io_pulseOut, 4'b0000);
    end
    @(negedge io_clk);
    io_rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus.io_pulseOut !== 4'b0110) begin
      failed++; $display("FAIL idle_follow got=%b exp=%b", bus.io_pulseOut, 4'b0110);
    end
  endtask

  task automatic test_basic_train(input string name);
    set_defaults(4'b0000);
    set_cfg(0, 0, 10, 25, 3);
    bus.io_en[0] = 1'b1;
    push_train(0, 0, 10, 25, 3, 1'b0, 0);
    for (int t = 0; t < 64; t++) begin
      tick();
      bus.io_en = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        logic [2:0] g_v, e_v;
        g_v = {bus.io_pulseOut[ch], bus.busy[ch], bus.pulse_valid[ch]};
        if (exp_q[ch].size() > 0) e_v = exp_q[ch].pop_front();
        else                      e_v = {bus.io_defaultLevel[ch], 2'b00};
        tests_run++;
        if (g_v !== e_v) begin
          failed++; $display("FAIL %s ch%0d cyc%0d got=%b exp=%b", name, ch, t, g_v, e_v);
        end
      end
    end
  endtask

  task automatic test_delay_gap();
    set_defaults(4'b0010);
    set_cfg(1, 5, 4, 4, 2);
    bus.io_en[1] = 1'b1;
    push_train(1, 5, 4, 4, 2, 1'b1, 0);
    for (int t = 0; t < 18; t++) begin
      tick();
      bus.io_en = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        logic [2:0] g_v, e_v;
        g_v = {bus.io_pulseOut[ch], bus.busy[ch], bus.pulse_valid[ch]};
        if (exp_q[ch].size() > 0) e_v = exp_q[ch].pop_front();
        else                      e_v = {bus.io_defaultLevel[ch], 2'b00};
        tests_run++;
        if (g_v !== e_v) begin
          failed++; $display("FAIL delay_gap ch%0d cyc%0d got=%b exp=%b", ch, t, g_v, e_v);
        end
      end
    end
  endtask

  task automatic test_continuous_abort();
    set_defaults(4'b0000);
    set_cfg(2, 2, 3, 8, 0);
    bus.io_en[2] = 1'b1;
    push_train(2, 2, 3, 8, 0, 1'b0, 7);
    for (int t = 0; t < 62; t++) begin
      tick();
      bus.io_en   = '0;
      bus.pwm_dis = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        logic [2:0] g_v, e_v;
        g_v = {bus.io_pulseOut[ch], bus.busy[ch], bus.pulse_valid[ch]};
        if (exp_q[ch].size() > 0) e_v = exp_q[ch].pop_front();
        else                      e_v = {bus.io_defaultLevel[ch], 2'b00};
        tests_run++;
        if (g_v !== e_v) begin
          failed++; $display("FAIL cont_abort ch%0d cyc%0d got=%b exp=%b", ch, t, g_v, e_v);
        end
      end
      if (exp_q[2].size() == 1) bus.pwm_dis[2] = 1'b1;
    end
  endtask

  task automatic test_zero_width();
    set_defaults(4'b1000);
    set_cfg(3, 3, 0, 6, 5);
    bus.io_en[3] = 1'b1;
    push_train(3, 3, 0, 6, 5, 1'b1, 0);
    for (int t = 0; t < 5; t++) begin
      tick();
      bus.io_en = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        logic [2:0] g_v, e_v;
        g_v = {bus.io_pulseOut[ch], bus.busy[ch], bus.pulse_valid[ch]};
        if (exp_q[ch].size() > 0) e_v = exp_q[ch].pop_front();
        else                      e_v = {bus.io_defaultLevel[ch], 2'b00};
        tests_run++;
        if (g_v !== e_v) begin
          failed++; $display("FAIL zero_width ch%0d cyc%0d got=%b exp=%b", ch, t, g_v, e_v);
        end
      end
    end
    set_cfg(3, 0, 4, 6, 2);
    bus.io_en[3]   = 1'b1;
    bus.pwm_dis[3] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      bus.io_en   = '0;
      bus.pwm_dis = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        logic [2:0] g_v, e_v;
        g_v = {bus.io_pulseOut[ch], bus.busy[ch], bus.pulse_valid[ch]};
        e_v = {bus.io_defaultLevel[ch], 2'b00};
        tests_run++;
        if (g_v !== e_v) begin
          failed++; $display("FAIL en_with_dis ch%0d cyc%0d got=%b exp=%b", ch, t, g_v, e_v);
        end
      end
    end
  endtask

  task automatic test_multi_channel();
    int d_a[N_CH], w_a[N_CH], p_a[N_CH], c_a[N_CH], st_a[N_CH];
    logic [N_CH-1:0] defs;
    for (int ch = 0; ch < N_CH; ch++) begin
      d_a[ch]  = $urandom_range(0, 4);
      w_a[ch]  = $urandom_range(3, 6);
      p_a[ch]  = $urandom_range(1, 10);
      c_a[ch]  = $urandom_range(1, 3);
      defs[ch] = 1'($urandom_range(0, 1));
    end
    st_a[0] = 0; st_a[1] = 3; st_a[2] = 5; st_a[3] = 8;
    set_defaults(defs);
    for (int t = 0; t < 60; t++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        bus.io_en[ch] = (t == st_a[ch]) || (t == st_a[ch] + 2);
        if (t == st_a[ch]) begin
          set_cfg(ch, d_a[ch], w_a[ch], p_a[ch], c_a[ch]);
          push_train(ch, d_a[ch], w_a[ch], p_a[ch], c_a[ch], defs[ch], 0);
        end
        // Scrambled fields while busy must not disturb the running train.
        if (t == st_a[ch] + 1) set_cfg(ch, 1, 1, 2, 9);
      end
      tick();
      for (int ch = 0; ch < N_CH; ch++) begin
        logic [2:0] g_v, e_v;
        g_v = {bus.io_pulseOut[ch], bus.busy[ch], bus.pulse_valid[ch]};
        if (exp_q[ch].size() > 0) e_v = exp_q[ch].pop_front();
        else                      e_v = {bus.io_defaultLevel[ch], 2'b00};
        tests_run++;
        if (g_v !== e_v) begin
          failed++; $display("FAIL multi ch%0d cyc%0d got=%b exp=%b", ch, t, g_v, e_v);
        end
      end
    end
    bus.io_en = '0;
  endtask

  task automatic test_reset_mid_train();
    set_defaults(4'b0000);
    set_cfg(0, 0, 10, 25, 3);
    bus.io_en[0] = 1'b1;
    push_train(0, 0, 10, 25, 3, 1'b0, 0);
    for (int t = 0; t < 5; t++) begin
      tick();
      bus.io_en = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        logic [2:0] g_v, e_v;
        g_v = {bus.io_pulseOut[ch], bus.busy[ch], bus.pulse_valid[ch]};
        if (exp_q[ch].size() > 0) e_v = exp_q[ch].pop_front();
        else                      e_v = {bus.io_defaultLevel[ch], 2'b00};
        tests_run++;
        if (g_v !== e_v) begin
          failed++; $display("FAIL pre_reset ch%0d cyc%0d got=%b exp=%b", ch, t, g_v, e_v);
        end
      end
    end
    #2;
    io_rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.io_pulseOut[0] !== 1'b0) begin
      failed++; $display("FAIL async_rst_out got=%b exp=%b", bus.io_pulseOut[0], 1'b0);
    end
    tests_run++;
    if (bus.busy[0] !== 1'b0) begin
      failed++; $display("FAIL async_rst_busy got=%b exp=%b", bus.busy[0], 1'b0);
    end
    exp_q[0].delete();
    tick();
    tests_run++;
    if ({bus.io_pulseOut[0], bus.busy[0], bus.pulse_valid[0]} !== 3'b000) begin
      failed++; $display("FAIL rst_no_pv got=%b exp=%b",
                         {bus.io_pulseOut[0], bus.busy[0], bus.pulse_valid[0]}, 3'b000);
    end
    @(negedge io_clk);
    io_rst_n = 1'b1;
    test_basic_train("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_train("basic");
    test_delay_gap();
    test_continuous_abort();
    test_zero_width();
    test_multi_channel();
    test_reset_mid_train();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
